// File: rtl/shift_seq.sv
`default_nettype none
// shift_seq: sequential 64-bit SLL/SRL/SRA, applying at most STEP bits per cycle.
// Define SHIFT_SEQ_WORD_EN to compile in RV64 W-variant (req_word) support.
module shift_seq #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [5:0]  req_shamt,
  input  logic        req_word,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_y,
  output logic        busy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [5:0] C_STEP = 6'(STEP);

`ifdef SHIFT_SEQ_WORD_EN
  localparam logic C_WORD_EN = 1'b1;
`else
  localparam logic C_WORD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic        word_q;
  logic [63:0] work_q;
  logic [5:0]  rem_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_y_q;

  logic        word_d;
  logic [5:0]  shamt_d;
  logic [63:0] operand_d;
  logic [5:0]  step_d;
  logic [5:0]  rem_d;
  logic [63:0] work_d;

  // Word-mode results keep only the low 32 bits, sign-extended.
  function automatic logic [63:0] fold(input logic w, input logic [63:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    word_d    = C_WORD_EN & req_word;
    shamt_d   = word_d ? {1'b0, req_shamt[4:0]} : req_shamt;
    operand_d = req_a;
    if (word_d) begin
      operand_d = (req_op == OP_SRA) ? {{32{req_a[31]}}, req_a[31:0]}
                                     : {32'h0, req_a[31:0]};
    end
  end

  always_comb begin
    step_d = (rem_q < C_STEP) ? rem_q : C_STEP;
    rem_d  = rem_q - step_d;
    case (op_q)
      OP_SLL:  work_d = work_q << step_d;
      OP_SRL:  work_d = work_q >> step_d;
      OP_SRA:  work_d = $signed(work_q) >>> step_d;
      default: work_d = work_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SLL;
      word_q      <= 1'b0;
      work_q      <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            word_q <= word_d;
            work_q <= operand_d;
            rem_q  <= shamt_d;
            if (shamt_d == 6'd0 || req_op == OP_RSV) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_y_q     <= (req_op == OP_RSV) ? req_a : fold(word_d, operand_d);
              rem_q       <= '0;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == 6'd0) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_y_q     <= fold(word_q, work_d);
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;

endmodule
`default_nettype wire
